signal_cfg_commit_ctrl: RTL and testbench

// Shadow/commit controller for the 832-bit DAC signal configuration word (offset, ramp, 4 components).

---
 rtl/signal_cfg_commit_ctrl_pkg.sv | 19 +
 rtl/signal_cfg_commit_ctrl_if.sv | 25 ++
 rtl/signal_cfg_stage_regs.sv | 44 ++++
 rtl/signal_cfg_commit_ctrl.sv | 53 +++++
 tb/tb_signal_cfg_commit_ctrl.sv | 127 ++++++++++++
 5 files changed

// File: rtl/signal_cfg_commit_ctrl_pkg.sv
// signal_cfg_commit_ctrl_pkg: shared constants, FSM states and config field layout.
package signal_cfg_commit_ctrl_pkg;
  localparam int CFG_WIDTH = 832;
  localparam int WORD_W = 32;
  localparam int NUM_WORDS = CFG_WIDTH / WORD_W;
  localparam int ADDR_W = 5;
  localparam int OFF_OFFSET = 0;
  localparam int OFF_RAMP = 32;
  localparam int COMP_BASE = 64;
  localparam int COMP_STRIDE = 192;
  localparam int COMP_CFG = 0;
  localparam int COMP_AMP = 32;
  localparam int COMP_FREQ = 64;
  localparam int COMP_PHASE = 128;
  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_e;
  function automatic int comp_field_lsb(input int n, input int field_off);
    return COMP_BASE + n * COMP_STRIDE + field_off;
  endfunction
endpackage

// File: rtl/signal_cfg_commit_ctrl_if.sv
// signal_cfg_commit_ctrl_if: register-write, commit-control and active-config bundle.
interface signal_cfg_commit_ctrl_if;
  import signal_cfg_commit_ctrl_pkg::*;
  logic wr_valid;
  logic wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic commit_req;
  logic commit_sync;
  logic commit_cancel;
  logic sync_tick;
  logic [CFG_WIDTH-1:0] cfg_data;
  logic cfg_update;
  logic busy;
  logic [NUM_WORDS-1:0] dirty;
  logic addr_err;
  modport master (
    output wr_valid, wr_addr, wr_data, commit_req, commit_sync, commit_cancel, sync_tick,
    input wr_ready, cfg_data, cfg_update, busy, dirty, addr_err
  );
  modport slave (
    input wr_valid, wr_addr, wr_data, commit_req, commit_sync, commit_cancel, sync_tick,
    output wr_ready, cfg_data, cfg_update, busy, dirty, addr_err
  );
endinterface

// File: rtl/signal_cfg_stage_regs.sv
// signal_cfg_stage_regs: staging word array with per-word dirty mask and sticky address error.
module signal_cfg_stage_regs
  import signal_cfg_commit_ctrl_pkg::*;
(
  input  logic                 aclk_i,
  input  logic                 aresetn_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [WORD_W-1:0]    data_i,
  input  logic                 clr_i,
  output logic [CFG_WIDTH-1:0] stage_o,
  output logic [NUM_WORDS-1:0] dirty_o,
  output logic                 addr_err_o
);
  logic [CFG_WIDTH-1:0] stage_q, stage_d;
  logic [NUM_WORDS-1:0] dirty_q, dirty_d;
  logic err_q, err_d;
  logic addr_ok;
  assign addr_ok = addr_i < ADDR_W'(NUM_WORDS);
  always_comb begin
    stage_d = stage_q;
    dirty_d = clr_i ? '0 : dirty_q;
    err_d = clr_i ? 1'b0 : err_q;
    if (we_i && addr_ok) begin
      stage_d[addr_i*WORD_W +: WORD_W] = data_i;
      dirty_d[addr_i] = 1'b1;
    end
    if (we_i && !addr_ok) err_d = 1'b1;
  end
  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      stage_q <= '0;
      dirty_q <= '0;
      err_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      dirty_q <= dirty_d;
      err_q <= err_d;
    end
  end
  assign stage_o = stage_q;
  assign dirty_o = dirty_q;
  assign addr_err_o = err_q;
endmodule

// File: rtl/signal_cfg_commit_ctrl.sv
// signal_cfg_commit_ctrl: shadow/commit controller copying staging into the active config word
// atomically, either immediately or at the next sync_tick.
module signal_cfg_commit_ctrl
  import signal_cfg_commit_ctrl_pkg::*;
(
  input logic aclk_i,
  input logic aresetn_i,
  signal_cfg_commit_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_d, stage;
  logic upd_q, upd_d;
  logic apply;
  assign apply = state_q == APPLY;
  assign bus.wr_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  signal_cfg_stage_regs u_stage (
    .aclk_i     (aclk_i),
    .aresetn_i  (aresetn_i),
    .we_i       (bus.wr_valid & bus.wr_ready),
    .addr_i     (bus.wr_addr),
    .data_i     (bus.wr_data),
    .clr_i      (apply),
    .stage_o    (stage),
    .dirty_o    (bus.dirty),
    .addr_err_o (bus.addr_err)
  );
  // cancel is checked before sync_tick so a coincident pair aborts the commit
  always_comb begin
    state_d = state_q;
    cfg_d = apply ? stage : cfg_q;
    upd_d = apply;
    unique case (state_q)
      IDLE:    if (bus.commit_req) state_d = bus.commit_sync ? ARMED : APPLY;
      ARMED:   state_d = bus.commit_cancel ? IDLE : (bus.sync_tick ? APPLY : ARMED);
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      state_q <= IDLE;
      cfg_q <= '0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      upd_q <= upd_d;
    end
  end
  assign bus.cfg_data = cfg_q;
  assign bus.cfg_update = upd_q;
endmodule

// File: tb/tb_signal_cfg_commit_ctrl.sv
// tb_signal_cfg_commit_ctrl: directed and random stimulus checked against a cycle-level behavioural model.
module tb_signal_cfg_commit_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  signal_cfg_commit_ctrl_if bus();
  signal_cfg_commit_ctrl dut (.aclk_i(clk), .aresetn_i(rstn), .bus(bus));

  logic [831:0] m_stage, m_active;
  logic [25:0]  m_dirty;
  bit m_err, m_armed, m_apply, m_upd;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [831:0] obs, input logic [831:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, update the model from the inputs seen at that edge, then compare
  task automatic cyc();
    bit rdy, a, p;
    @(posedge clk);
    if (!rstn) begin
      m_stage = '0; m_active = '0; m_dirty = '0;
      m_err = 0; m_armed = 0; m_apply = 0; m_upd = 0;
    end else begin
      rdy = !m_armed && !m_apply;
      m_upd = m_apply;
      if (m_apply) begin
        m_active = m_stage; m_dirty = '0; m_err = 0;
      end
      if (rdy && bus.wr_valid) begin
        if (bus.wr_addr < 26) begin
          m_stage[bus.wr_addr*32 +: 32] = bus.wr_data;
          m_dirty[bus.wr_addr] = 1'b1;
        end else m_err = 1;
      end
      a = (rdy && bus.commit_req && bus.commit_sync) || (m_armed && !bus.sync_tick && !bus.commit_cancel);
      p = (rdy && bus.commit_req && !bus.commit_sync) || (m_armed && bus.sync_tick && !bus.commit_cancel);
      m_armed = a;
      m_apply = p;
    end
    #1;
    check("cfg_data", bus.cfg_data, m_active);
    check("dirty", 832'(bus.dirty), 832'(m_dirty));
    check("addr_err", 832'(bus.addr_err), 832'(m_err));
    check("busy", 832'(bus.busy), 832'(m_armed || m_apply));
    check("wr_ready", 832'(bus.wr_ready), 832'(!m_armed && !m_apply));
    check("cfg_update", 832'(bus.cfg_update), 832'(m_upd));
  endtask

  task automatic drv(input bit v, input int adr, input logic [31:0] d,
                     input bit req, input bit sync, input bit cancel, input bit tick);
    bus.wr_valid = v; bus.wr_addr = 5'(adr); bus.wr_data = d;
    bus.commit_req = req; bus.commit_sync = sync; bus.commit_cancel = cancel; bus.sync_tick = tick;
    cyc();
    bus.wr_valid = 0; bus.commit_req = 0; bus.commit_sync = 0; bus.commit_cancel = 0; bus.sync_tick = 0;
  endtask

  initial begin
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.commit_req = 0; bus.commit_sync = 0; bus.commit_cancel = 0; bus.sync_tick = 0;
    // reset with writes pending
    rstn = 0;
    drv(1, 2, 32'hAAAA_5555, 0, 0, 0, 0);
    drv(1, 4, 32'h1111_2222, 1, 0, 0, 0);
    rstn = 1;
    check("rst_cfg", bus.cfg_data, '0);
    check("rst_ready", 832'(bus.wr_ready), 832'(1));
    // immediate commit, last write in the same cycle as the request
    drv(1, 0, 32'h0000_1234, 0, 0, 0, 0);
    drv(1, 25, 32'hDEAD_BEEF, 1, 0, 0, 0);
    check("imm_not_yet", 832'(bus.cfg_data[15:0]), 832'(0));
    drv(0, 0, 0, 0, 0, 0, 0);
    check("imm_lo", 832'(bus.cfg_data[15:0]), 832'(16'h1234));
    check("imm_hi", 832'(bus.cfg_data[831:800]), 832'(32'hDEAD_BEEF));
    check("imm_upd", 832'(bus.cfg_update), 832'(1));
    drv(0, 0, 0, 0, 0, 0, 0);
    check("imm_upd_off", 832'(bus.cfg_update), 832'(0));
    // synced commit, writes stalled while armed
    drv(1, 3, 32'hCAFE_F00D, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) drv(1, 3, $urandom, 0, 0, 0, 0);
    check("armed_ready", 832'(bus.wr_ready), 832'(0));
    drv(0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    check("sync_w3", 832'(bus.cfg_data[127:96]), 832'(32'hCAFE_F00D));
    // commit_req coincident with sync_tick waits for the next tick
    drv(1, 7, 32'h0BAD_CAFE, 1, 1, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    check("same_cyc_wait", 832'(bus.busy), 832'(1));
    drv(0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    check("same_cyc_w7", 832'(bus.cfg_data[255:224]), 832'(32'h0BAD_CAFE));
    // cancel wins over a coincident tick
    drv(1, 9, 32'h1357_9BDF, 1, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    check("cancel_kept", 832'(bus.cfg_data[319:288]), 832'(0));
    check("cancel_dirty", 832'(bus.dirty[9]), 832'(1));
    // bad address, then reset while armed
    drv(1, 26, 32'hFFFF_FFFF, 0, 0, 0, 0);
    check("bad_addr", 832'(bus.addr_err), 832'(1));
    drv(1, 5, 32'h5555_AAAA, 1, 1, 0, 0);
    rstn = 0;
    drv(0, 0, 0, 0, 0, 0, 1);
    rstn = 1;
    drv(0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    check("rst_armed", bus.cfg_data, '0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 149) != 0);
      drv($urandom_range(0, 1), $urandom_range(0, 27), $urandom,
          $urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
          $urandom_range(0, 4) == 0);
    end
    rstn = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
